rs_ap_ctrl_pipeline_head: RTL
=============================

// Module: rs_ap_ctrl_pipeline_head
// PURPOSE
// - Source-side end of a pipelined ap_ctrl link; pairs with the sink-side tail across slot boundaries.
// - Turns the host's level ap_start into exactly one start token per transaction.
// - Returns ap_ready to the host only once the pipelined ready pulse comes back from the far end.
// - Counts tokens still in flight (accepted, ap_done not yet seen) to drive ap_idle and to throttle issue.
// PARAMETERS
// - MAX_OUTSTANDING  default 4   max accepted tokens without a returned done; issue stalls at this count
// - CNT_WIDTH        default $clog2(MAX_OUTSTANDING+1)   width of the in-flight counter (derived; do not override)
// - __REGION         default ""  floorplan region tag, passed to sub-module
// PORTS
// - clk           in   1  clock
// - reset_n       in   1  asynchronous, active-low reset
// - ap_start      in   1  host start (level, held until ap_ready)
// - ap_ready      out  1  one-cycle pulse to host: transaction accepted end-to-end
// - ap_done       out  1  registered copy of done_in (1-cycle pulse)
// - ap_idle       out  1  high when state==IDLE and in-flight count==0
// - if_empty_n    out  1  start token valid toward pipeline
// - if_read       in   1  pipeline accepts token (handshake when if_empty_n & if_read)
// - ready_in      in   1  pipelined ap_ready returning from far end (pulse)
// - done_in       in   1  pipelined ap_done returning from far end (pulse)
// - err_spurious  out  1  sticky: ready_in seen outside WAIT_READY
// - err_underflow out  1  sticky: done_in seen with in-flight count 0
// BEHAVIOUR
// - Reset (async assert, sync deassert by system): state=IDLE, count=0; ap_ready=0, ap_done=0, if_empty_n=0,
//   ap_idle=1, err_*=0. Reset mid-transaction drops the token and count; no pulse is emitted afterward.
// - All outputs are registered; no combinational path exists from any input to any output.
// - FSM states:
//   - IDLE: if ap_start & count<MAX_OUTSTANDING -> ISSUE; otherwise stay.
//   - ISSUE: if_empty_n=1. Handshake (if_read=1) -> WAIT_READY and count+1 in the same edge.
//     Dropping ap_start in ISSUE is a host protocol violation; the token still completes.
//   - WAIT_READY: if_empty_n=0, ap_start ignored. ready_in -> ACK.
//   - ACK: ap_ready=1 for exactly this cycle -> IDLE. ap_start still high in IDLE starts the next transaction.
// - Latency:
//   - ap_start rise at cycle t -> if_empty_n=1 at t+1.
//   - ready_in at cycle m -> ap_ready=1 at m+1.
//   - Next token no earlier than m+3.
// - Counter: +1 on handshake, -1 on done_in.
//   - Both in the same cycle -> count unchanged.
//   - done_in at count 0 -> count stays 0 and err_underflow is set.
//   - The counter never wraps.
// - Throttle: at count==MAX_OUTSTANDING, IDLE holds off issue; if_empty_n stays 0 until a done_in frees a slot.
// - ap_done = done_in delayed by one cycle, unconditionally (including the underflow case).
// - ready_in in IDLE/ISSUE/ACK: ignored for FSM, sets err_spurious. Error flags clear only on reset.
// - ap_idle is computed from next-state/next-count so it is registered yet exact.
// STRUCTURE
// - Shared package rs_ap_ctrl_pkg:
//   - 2-bit state encoding: IDLE=2'b00, ISSUE=2'b01, WAIT_READY=2'b10, ACK=2'b11.
//   - Count-width helper function.
// - Sub-module rs_ap_ctrl_credit_counter (inc, dec, count, full, empty, underflow).
//   - Saturating at 0; asserts no overflow.
// - FSM, output registers and sticky error flags in the top.
// TESTING
// - Single txn: ap_start=1 at c0, if_read at c3, ready_in at c10, ap_start=0 at c11 ->
//   if_empty_n 1 on c1..c3; ap_ready=1 only at c11; count=1; done_in at c20 -> ap_done at c21, ap_idle=1 at c21.
// - Back-to-back: ap_start held, if_read tied 1, ready_in 2 cycles after each handshake ->
//   one token per ap_ready pulse; never two tokens without an intervening ready_in.
// - Throttle, MAX_OUTSTANDING=2, no done_in: third issue blocked with if_empty_n=0 ->
//   one done_in -> if_empty_n=1 two cycles later.
// - Simultaneous if_read handshake and done_in at count=1 -> count stays 1; ap_idle=0.
// - Errors: ready_in in IDLE -> err_spurious=1, state stays IDLE.
//   done_in at count 0 -> err_underflow=1, ap_done pulses, count 0.
// - Reset mid-op: assert reset_n=0 async during WAIT_READY with count=3 ->
//   all outputs at reset values immediately; no ap_ready after release even if ready_in arrives.

Source files
------------

// File: rtl/rs_ap_ctrl_pkg.sv
// rtl/rs_ap_ctrl_pkg.sv - shared state encoding and sizing helper for the ap_ctrl pipeline head
package rs_ap_ctrl_pkg;

    // FSM encoding is shared with the sink-side tail, so it stays as plain 2-bit constants.
    localparam logic [1:0] ST_IDLE       = 2'b00;
    localparam logic [1:0] ST_ISSUE      = 2'b01;
    localparam logic [1:0] ST_WAIT_READY = 2'b10;
    localparam logic [1:0] ST_ACK        = 2'b11;

    // Width needed to hold 0..max_outstanding inclusive.
    function automatic int cnt_width(input int max_outstanding);
        return (max_outstanding < 1) ? 1 : $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/rs_ap_ctrl_pipeline_head_credit_counter.sv
// rtl/rs_ap_ctrl_pipeline_head_credit_counter.sv - in-flight token counter, saturating at 0 and MAX_COUNT
// Ports:
//   clk, reset_n        clock, async active-low reset
//   inc, dec            token accepted / done returned (both -> unchanged)
//   count, count_next   current and next in-flight count
//   full, empty         count == MAX_COUNT / count == 0
//   underflow           dec seen while count == 0
module rs_ap_ctrl_credit_counter
    import rs_ap_ctrl_pkg::*;
#(
    parameter int    MAX_COUNT = 4,
    parameter int    CNT_WIDTH = cnt_width(MAX_COUNT),
    parameter string __REGION  = ""
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] count_next,
    output logic                 full,
    output logic                 empty,
    output logic                 underflow
);

    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_COUNT);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    assign full      = (count_q == MAX_C);
    assign empty     = (count_q == '0);
    assign underflow = dec && empty;

    // Guards make the counter hold at both ends instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (!full) count_d = count_q + CNT_WIDTH'(1);
        end else if (dec && !inc) begin
            if (!empty) count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign count      = count_q;
    assign count_next = count_d;

    // The issuing FSM throttles on full, so an increment at full means a logic bug upstream.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(inc && !dec && full));

endmodule

// File: rtl/rs_ap_ctrl_pipeline_head.sv
// rtl/rs_ap_ctrl_pipeline_head.sv - source-side ap_ctrl head: one token per start, end-to-end ready, in-flight tracking
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   ap_start / ap_ready           host level start, one-cycle accept pulse back to host
//   ap_done / ap_idle             registered done_in copy, idle (no FSM activity, nothing in flight)
//   if_empty_n / if_read          start token valid toward pipeline / pipeline accepts it
//   ready_in / done_in            pipelined ready and done pulses from the far end
//   err_spurious / err_underflow  sticky protocol error flags
module rs_ap_ctrl_pipeline_head
    import rs_ap_ctrl_pkg::*;
#(
    parameter int    MAX_OUTSTANDING = 4,
    parameter int    CNT_WIDTH       = cnt_width(MAX_OUTSTANDING),
    parameter string __REGION        = ""
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ap_start,
    output logic ap_ready,
    output logic ap_done,
    output logic ap_idle,
    output logic if_empty_n,
    input  logic if_read,
    input  logic ready_in,
    input  logic done_in,
    output logic err_spurious,
    output logic err_underflow
);

    logic [1:0] state_q, state_d;
    logic       ap_ready_q, ap_ready_d;
    logic       ap_done_q, ap_done_d;
    logic       ap_idle_q, ap_idle_d;
    logic       if_empty_n_q, if_empty_n_d;
    logic       err_spurious_q, err_spurious_d;
    logic       err_underflow_q, err_underflow_d;

    logic                 handshake;
    logic [CNT_WIDTH-1:0] cnt_count;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 cnt_full;
    logic                 cnt_empty;
    logic                 cnt_underflow;

    assign handshake = (state_q == ST_ISSUE) && if_read;

    rs_ap_ctrl_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_WIDTH (CNT_WIDTH),
        .__REGION  (__REGION)
    ) u_credit (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (handshake),
        .dec        (done_in),
        .count      (cnt_count),
        .count_next (cnt_next),
        .full       (cnt_full),
        .empty      (cnt_empty),
        .underflow  (cnt_underflow)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (ap_start && !cnt_full) state_d = ST_ISSUE;
            ST_ISSUE:      if (if_read)               state_d = ST_WAIT_READY;
            ST_WAIT_READY: if (ready_in)              state_d = ST_ACK;
            default:                                  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered but not a cycle late.
        if_empty_n_d    = (state_d == ST_ISSUE);
        ap_ready_d      = (state_d == ST_ACK);
        ap_idle_d       = (state_d == ST_IDLE) && (cnt_next == '0);
        ap_done_d       = done_in;
        err_spurious_d  = err_spurious_q | (ready_in && (state_q != ST_WAIT_READY));
        err_underflow_d = err_underflow_q | cnt_underflow;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            ap_ready_q      <= 1'b0;
            ap_done_q       <= 1'b0;
            ap_idle_q       <= 1'b1;
            if_empty_n_q    <= 1'b0;
            err_spurious_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ap_ready_q      <= ap_ready_d;
            ap_done_q       <= ap_done_d;
            ap_idle_q       <= ap_idle_d;
            if_empty_n_q    <= if_empty_n_d;
            err_spurious_q  <= err_spurious_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign ap_ready      = ap_ready_q;
    assign ap_done       = ap_done_q;
    assign ap_idle       = ap_idle_q;
    assign if_empty_n    = if_empty_n_q;
    assign err_spurious  = err_spurious_q;
    assign err_underflow = err_underflow_q;

    // ap_idle is precomputed from next-state values; it must always agree with the current ones.
    a_idle_exact: assert property (@(posedge clk) disable iff (!reset_n)
        ap_idle_q == ((state_q == ST_IDLE) && cnt_empty));
    a_empty_exact: assert property (@(posedge clk) disable iff (!reset_n)
        cnt_empty == (cnt_count == '0));

endmodule
